// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the fifo and its read adapter
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 4;

    // Output-buffer occupancy, legal values 0..2.
    typedef logic [1:0] occ_t;

    localparam occ_t OCC_MAX = 2'd2;

    // Occupancy after one edge; one bit wider so an overflow stays visible.
    function automatic logic [2:0] occ_sum(input occ_t occ, input logic add, input logic sub);
        return {1'b0, occ} + {2'b00, add} - {2'b00, sub};
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry output buffer that absorbs the fifo read latency
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout,
    output occ_t                  o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    occ_t                  r_occ;

    logic                  w_pop;
    logic [2:0]            w_occ_sum;

    // A pop on an empty buffer cannot move the head.
    assign w_pop     = i_pop && (r_occ != 2'd0);
    assign w_occ_sum = occ_sum(r_occ, i_push, w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ <= w_occ_sum[1:0];
            assert (w_occ_sum <= 3'(OCC_MAX));
        end
    end

    assign o_dout = (r_occ != 2'd0) ? r_mem[r_rd_ptr] : '0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_adapter.sv
// rtl/fifo_rd_adapter.sv - drains a fifo into a valid/ready stream at one word per cycle
// Optional transfer counter enabled by FIFO_RD_ADAPTER_STATS_EN.
module fifo_rd_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    parameter int CNT_WIDTH  = 16
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    output logic                  o_fifo_rd,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data
`ifdef FIFO_RD_ADAPTER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_xfer_count
`endif
);

    logic       r_inflight;
    occ_t       w_occ;
    logic       w_pop;
    logic [2:0] w_level;

    assign o_out_valid = (w_occ != 2'd0);
    assign w_pop       = o_out_valid && i_out_ready;

    // Count the in-flight word as already buffered so the buffer can never overrun.
    assign w_level     = occ_sum(w_occ, r_inflight, w_pop);
    assign o_fifo_rd   = !i_fifo_empty && (w_level < 3'(OCC_MAX));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= o_fifo_rd;
        end
    end

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (r_inflight),
        .i_pop  (w_pop),
        .i_din  (i_fifo_data),
        .o_dout (o_out_data),
        .o_occ  (w_occ)
    );

`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [CNT_WIDTH-1:0] r_xfer_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xfer_count <= '0;
        end else if (w_pop) begin
            r_xfer_count <= r_xfer_count + 1'b1;
        end
    end

    assign o_xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// tb/tb_fifo_rd_adapter.sv - scoreboard bench for fifo_rd_adapter with a behavioural fifo
module tb_fifo_rd_adapter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty;
    logic [3:0] fifo_data;
    logic       fifo_rd;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
`ifdef FIFO_RD_ADAPTER_STATS_EN
    logic [15:0] xfer_count;
`endif

    logic       wr_en = 1'b0;
    logic [3:0] wr_d  = 4'h0;
    logic [3:0] fq [$];
    logic [3:0] sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    fifo_rd_adapter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fifo_empty (fifo_empty),
        .i_fifo_data  (fifo_data),
        .o_fifo_rd    (fifo_rd),
        .o_out_valid  (out_valid),
        .i_out_ready  (out_ready),
        .o_out_data   (out_data)
`ifdef FIFO_RD_ADAPTER_STATS_EN
        ,
        .o_xfer_count (xfer_count)
`endif
    );

    // Upstream fifo: data_out registered one cycle after rd, cleared by the shared reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            fifo_empty <= 1'b1;
            fifo_data  <= 4'h0;
        end else begin
            if (wr_en) fq.push_back(wr_d);
            if (fifo_rd && fq.size() != 0) fifo_data <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic cyc(input logic rdy, input logic we, input logic [3:0] wd);
        @(negedge clk);
        out_ready = rdy;
        wr_en     = we;
        wr_d      = wd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_hold: rd=%b valid=%b data=%h, required 0/0/0", fifo_rd, out_valid, out_data);
        end
`ifdef FIFO_RD_ADAPTER_STATS_EN
        n_tests++;
        if (xfer_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: xfer_count=%0d, required 0", xfer_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 4'h0);
            n_tests++;
            if (fifo_rd !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: rd=%b valid=%b data=%h, required 0/0/0", i, fifo_rd, out_valid, out_data);
            end
        end
    endtask

    task automatic test_single();
        int rd_cnt = 0;
        int rd_cyc = -100;
        int v_cnt  = 0;
        logic [3:0] exp;
        cyc(1'b1, 1'b1, 4'hA);
        sb.push_back(4'hA);
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b0, 4'h0);
            if (fifo_rd) begin
                rd_cnt++;
                rd_cyc = i;
            end
            if (out_valid) begin
                v_cnt++;
                n_tests++;
                if (i !== rd_cyc + 2) begin
                    n_fail++;
                    $display("FAIL single_latency: word at cycle %0d, required %0d", i, rd_cyc + 2);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL single_data: unexpected word %h, required none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL single_data: got %h, required %h", out_data, exp);
                    end
                end
            end
        end
        n_tests++;
        if (rd_cnt !== 1 || v_cnt !== 1) begin
            n_fail++;
            $display("FAIL single_counts: rd pulses=%0d valid cycles=%0d, required 1/1", rd_cnt, v_cnt);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: %0d words left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_burst();
        int rd_cnt = 0, rd_first = -1, rd_last = -1;
        int v_cnt = 0, v_first = -1, v_last = -1;
        logic [3:0] exp;
        logic       we;
`ifdef FIFO_RD_ADAPTER_STATS_EN
        logic [15:0] cnt0;
        cnt0 = xfer_count;
`endif
        for (int i = 0; i < 14; i++) begin
            we = (i < 4);
            if (we) sb.push_back(4'(i + 1));
            cyc(1'b1, we, 4'(i + 1));
            if (fifo_rd) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = i;
                rd_last = i;
            end
            if (out_valid && out_ready) begin
                v_cnt++;
                if (v_first < 0) v_first = i;
                v_last = i;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL burst_data: unexpected word %h, required none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL burst_data: got %h, required %h", out_data, exp);
                    end
                end
            end
        end
        n_tests++;
        if (rd_cnt !== 4 || rd_last - rd_first !== 3) begin
            n_fail++;
            $display("FAIL burst_rd: pulses=%0d span=%0d, required 4 consecutive", rd_cnt, rd_last - rd_first + 1);
        end
        n_tests++;
        if (v_cnt !== 4 || v_last - v_first !== 3) begin
            n_fail++;
            $display("FAIL burst_valid: words=%0d span=%0d, required 4 consecutive", v_cnt, v_last - v_first + 1);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_drain: %0d words left, required 0", sb.size());
            sb.delete();
        end
`ifdef FIFO_RD_ADAPTER_STATS_EN
        n_tests++;
        if (xfer_count !== 16'(cnt0 + 16'd4)) begin
            n_fail++;
            $display("FAIL burst_count: xfer_count=%0d, required %0d", xfer_count, cnt0 + 16'd4);
        end
`endif
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        logic [3:0] exp;
        logic       we;
        for (int i = 0; i < 12; i++) begin
            we = (i < 4);
            if (we) sb.push_back(4'(5 + i));
            cyc(1'b0, we, 4'(5 + i));
            if (fifo_rd) rd_cnt++;
            if (i >= 4) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== 4'h5 || fifo_rd !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d: valid=%b data=%h rd=%b, required 1/5/0", i, out_valid, out_data, fifo_rd);
                end
            end
        end
        n_tests++;
        if (rd_cnt > 2 || rd_cnt < 1) begin
            n_fail++;
            $display("FAIL bp_rd_count: pulses=%0d, required 1..2", rd_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 4'h0);
            if (out_valid && out_ready) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_data: unexpected word %h, required none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL bp_data: got %h, required %h", out_data, exp);
                    end
                end
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drain: %0d words left, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_alternating();
        logic [3:0] exp;
        logic [3:0] wd;
        logic       we;
        logic       prev_valid = 1'b0;
        logic       prev_pop   = 1'b0;
        logic [3:0] prev_data  = 4'h0;
        int         popped     = 0;
        for (int i = 0; i < 30; i++) begin
            we = (i < 6);
            wd = 4'($urandom_range(0, 15));
            if (we) sb.push_back(wd);
            cyc(1'(i % 2), we, wd);
            if (prev_valid && !prev_pop) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL alt_stall%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, prev_data);
                end
            end
            if (out_valid && out_ready) begin
                popped++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL alt_data: unexpected word %h, required none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL alt_data: got %h, required %h", out_data, exp);
                    end
                end
            end
            prev_valid = out_valid;
            prev_pop   = out_valid && out_ready;
            prev_data  = out_data;
        end
        n_tests++;
        if (sb.size() != 0 || popped !== 6) begin
            n_fail++;
            $display("FAIL alt_drain: %0d left, %0d popped, required 0/6", sb.size(), popped);
            sb.delete();
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp;
        int         popped = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, (i < 3), 4'(4'hD + i));
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 4'hD) begin
            n_fail++;
            $display("FAIL mrst_pre: valid=%b data=%h, required 1/d", out_valid, out_data);
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || fifo_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_async: valid=%b data=%h rd=%b, required 0/0/0", out_valid, out_data, fifo_rd);
        end
`ifdef FIFO_RD_ADAPTER_STATS_EN
        n_tests++;
        if (xfer_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mrst_count: xfer_count=%0d, required 0", xfer_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 4'hC);
        sb.push_back(4'hC);
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 4'h0);
            if (out_valid && out_ready) begin
                popped++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL mrst_data: unexpected word %h, required none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if (out_data !== exp) begin
                        n_fail++;
                        $display("FAIL mrst_data: got %h, required %h", out_data, exp);
                    end
                end
            end
        end
        n_tests++;
        if (popped !== 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL mrst_alone: %0d words out, %0d left, required 1/0", popped, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_alternating();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
